// File: rtl/sevseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package sevseg_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned SEG_W  = 7;

  // Active-high {g,f,e,d,c,b,a} patterns, indexed by hex nibble (entry 15 listed first).
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_e;

endpackage

// File: rtl/sevseg_decode.sv
// Hex nibble to active-high segment pattern; polarity is applied by the parent.
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup of the segment pattern
  always_comb begin
    seg_c = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed 7-segment scan driver with per-slot anti-ghost blanking and
// frame-synchronous value updates. Define SEVSEG_LZB_EN to enable
// leading-zero blanking.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 12500,
  parameter int unsigned BLANK_CYC      = 250,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [SEG_W-1:0]      seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     dig,
  output logic                  frame
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned VAL_W = 4 * DIGITS;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK  = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [SEG_W-1:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              SEG_DP_OFF = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VAL_W-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic               pend_vld_q, pend_vld_d;
  logic [VAL_W-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]  shadow_dp_q, shadow_dp_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]  dig_q, dig_d;
  logic               frame_q, frame_d;

  logic               slot_end_c;
  logic               frame_end_c;
  logic [3:0]         nib_c;
  logic [SEG_W-1:0]   dec_seg_c;
  logic [SEG_W-1:0]   lit_seg_c;
  logic [DIGITS-1:0]  lzb_c;
  logic [DIGITS-1:0]  dig_onehot_c;

  // Slot counter, digit index and BLANK/ON state sequencing
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    state_d     = state_q;
    slot_end_c  = (cnt_q == CNT_LAST);
    frame_end_c = slot_end_c && (idx_q == IDX_LAST);
    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    case (state_q)
      BLANK:   if (cnt_d >= CNT_BLANK) state_d = ON;
      ON:      if (slot_end_c) state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Pending capture on load; shadow only changes on the frame wrap cycle
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (frame_end_c) begin
      pend_vld_d = 1'b0;
      if (load) begin
        shadow_val_d = value;
        shadow_dp_d  = dp;
      end else if (pend_vld_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
      pend_vld_d = 1'b1;
    end
  end

  // Leading-zero mask: a digit blanks when it and every higher digit are zero
  always_comb begin
    lzb_c = '0;
`ifdef SEVSEG_LZB_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = int'(DIGITS) - 1; i > 0; i--) begin
        zero_run = zero_run && (shadow_val_q[4*i +: 4] == 4'h0);
        lzb_c[i] = zero_run;
      end
    end
`endif
  end

  // Select the nibble of the digit currently being scanned
  always_comb begin
    nib_c = shadow_val_q[4*idx_q +: 4];
  end

  sevseg_decode u_decode (
    .nibble (nib_c),
    .seg_c  (dec_seg_c)
  );

  // Next pin values from this cycle's scan state (pins lag by one cycle)
  always_comb begin
    dig_onehot_c = DIGITS'(1) << idx_q;
    lit_seg_c    = lzb_c[idx_q] ? '0 : dec_seg_c;
    dig_d        = DIG_OFF;
    seg_d        = SEG_OFF;
    seg_dp_d     = SEG_DP_OFF;
    frame_d      = frame_end_c;
    if (enable && (state_q == ON)) begin
      dig_d    = DIG_ACTIVE_LOW ? ~dig_onehot_c : dig_onehot_c;
      seg_d    = SEG_ACTIVE_LOW ? ~lit_seg_c : lit_seg_c;
      seg_dp_d = SEG_ACTIVE_LOW ? ~shadow_dp_q[idx_q] : shadow_dp_q[idx_q];
    end
  end

  // State, data and pin registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      seg_dp_q     <= SEG_DP_OFF;
      dig_q        <= DIG_OFF;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign dig    = dig_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver (4 digits, short scan period).
module tb_sevseg_scan_driver;

  localparam int unsigned DIGITS    = 4;
  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned BLANK_CYC = 2;
  localparam int          FRAME     = DIGITS * SCAN_DIV;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig;
  logic        frame;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute position within the frame plus shown/pending data
  int          m_pos = 0;
  int          shown_pos = -1;
  logic [15:0] m_sh_val = '0;
  logic [3:0]  m_sh_dp = '0;
  logic [15:0] m_pend_val = '0;
  logic [3:0]  m_pend_dp = '0;
  bit          m_pend_v = 1'b0;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dpv;
    int          digit;
    logic [3:0]  dig_exp;
    logic [6:0]  seg_exp;
    logic        sdp_exp;
  } vec_t;

  vec_t vecs[12];

  sevseg_scan_driver #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .load   (load),
    .value  (value),
    .dp     (dp),
    .seg    (seg),
    .seg_dp (seg_dp),
    .dig    (dig),
    .frame  (frame)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: predict the pins from the model, advance the model, compare
  task automatic tick();
    logic [12:0] exp;
    int          d;
    bit          fr;
    bit          lit;
    logic [6:0]  s;
    if (reset) begin
      exp        = {4'hF, 7'h7F, 1'b1, 1'b0};
      m_pos      = 0;
      shown_pos  = -1;
      m_sh_val   = '0;
      m_sh_dp    = '0;
      m_pend_v   = 1'b0;
    end else begin
      fr  = (m_pos == FRAME - 1);
      d   = m_pos / SCAN_DIV;
      lit = enable && ((m_pos % SCAN_DIV) >= BLANK_CYC);
      if (lit) begin
        s = hex7(m_sh_val[4*d +: 4]);
`ifdef SEVSEG_LZB_EN
        if (d != 0 && (m_sh_val >> (4*d)) == 16'h0) s = 7'h00;
`endif
        exp = {~(4'b0001 << d), ~s, ~m_sh_dp[d], fr};
      end else begin
        exp = {4'hF, 7'h7F, 1'b1, fr};
      end
      shown_pos = m_pos;
      if (fr) begin
        if (load) begin
          m_sh_val = value;
          m_sh_dp  = dp;
        end else if (m_pend_v) begin
          m_sh_val = m_pend_val;
          m_sh_dp  = m_pend_dp;
        end
        m_pend_v = 1'b0;
      end else if (load) begin
        m_pend_val = value;
        m_pend_dp  = dp;
        m_pend_v   = 1'b1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end
    @(posedge clock);
    #1;
    check("pins{dig,seg,dp,frame}", {19'd0, dig, seg, seg_dp, frame}, {19'd0, exp});
  endtask

  task automatic wait_shown(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (shown_pos != target && n < budget) begin
      tick();
      n++;
    end
    if (shown_pos != target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, slot position %0d required, still at %0d", name, target, shown_pos);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Load, let it reach the shadow at a frame wrap, then look at one lit digit
  task automatic show_digit(input int digit, input string name,
                            input logic [3:0] dig_exp, input logic [6:0] seg_exp);
    wait_shown(digit * SCAN_DIV + BLANK_CYC + 1, FRAME, name);
    check(name, {25'd0, dig, seg}, {25'd0, dig_exp, seg_exp});
  endtask

  initial begin
    int n;

    vecs[0]  = '{16'h12AF, 4'b0100, 0, 4'b1110, 7'h0E, 1'b1};
    vecs[1]  = '{16'h12AF, 4'b0100, 1, 4'b1101, 7'h08, 1'b1};
    vecs[2]  = '{16'h12AF, 4'b0100, 2, 4'b1011, 7'h24, 1'b0};
    vecs[3]  = '{16'h12AF, 4'b0100, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h1111, 4'b0000, 0, 4'b1110, 7'h79, 1'b1};
    vecs[5]  = '{16'h1111, 4'b0000, 3, 4'b0111, 7'h79, 1'b1};
    vecs[6]  = '{16'h0050, 4'b0001, 0, 4'b1110, 7'h40, 1'b0};
    vecs[7]  = '{16'h0050, 4'b0001, 1, 4'b1101, 7'h12, 1'b1};
    vecs[8]  = '{16'h8C9E, 4'b1000, 0, 4'b1110, 7'h06, 1'b1};
    vecs[9]  = '{16'h8C9E, 4'b1000, 1, 4'b1101, 7'h10, 1'b1};
    vecs[10] = '{16'h8C9E, 4'b1000, 2, 4'b1011, 7'h46, 1'b1};
    vecs[11] = '{16'h8C9E, 4'b1000, 3, 4'b0111, 7'h00, 1'b0};

    reset  = 1'b1;
    enable = 1'b1;
    load   = 1'b0;
    value  = '0;
    dp     = '0;
    tick();
    tick();
    reset = 1'b0;

    // Table vectors: decode, digit select and dp after a frame-aligned update
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].val, vecs[i].dpv);
      wait_shown(FRAME - 1, 2 * FRAME, "vec_frame");
      wait_shown(vecs[i].digit * SCAN_DIV + BLANK_CYC + 1, FRAME, "vec_slot");
      check($sformatf("vec%0d", i), {20'd0, dig, seg, seg_dp},
            {20'd0, vecs[i].dig_exp, vecs[i].seg_exp, vecs[i].sdp_exp});
    end

    // Two loads in one frame: the later one wins
    wait_shown(FRAME - 1, 2 * FRAME, "two_load_align");
    do_load(16'h2222, 4'b0000);
    repeat (5) tick();
    do_load(16'h3333, 4'b0000);
    wait_shown(FRAME - 1, 2 * FRAME, "two_load_frame");
    show_digit(2, "two_loads_last_wins", 4'b1011, 7'h30);

    // Load exactly on the wrap cycle appears in the very next frame
    wait_shown(FRAME - 2, 2 * FRAME, "wrap_load_align");
    do_load(16'h4444, 4'b0000);
    show_digit(0, "load_on_wrap", 4'b1110, 7'h19);

    // Enable low for 10 cycles mid-slot: pins dark, frame period unchanged
    wait_shown(FRAME - 1, 2 * FRAME, "enable_align");
    n = 0;
    do begin
      if (n == 5)  enable = 1'b0;
      if (n == 15) enable = 1'b1;
      tick();
      n++;
      if (n == 10) check("disabled_pins", {21'd0, dig, seg}, {21'd0, 4'hF, 7'h7F});
    end while (frame !== 1'b1 && n < 2 * FRAME);
    check("frame_period", 32'(n), 32'(FRAME));

    // Reset during a lit slot with a load pending: load is discarded
    wait_shown(SCAN_DIV + BLANK_CYC + 2, 2 * FRAME, "reset_align");
    do_load(16'h9999, 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    show_digit(0, "after_reset_digit0", 4'b1110, 7'h40);
    wait_shown(FRAME - 1, 2 * FRAME, "after_reset_frame");
    show_digit(1, "reset_drops_pending", 4'b1101, 7'h40);

`ifdef SEVSEG_LZB_EN
    // Leading-zero blanking
    do_load(16'h0050, 4'b0000);
    wait_shown(FRAME - 1, 2 * FRAME, "lzb_frame0");
    show_digit(0, "lzb_0050_d0", 4'b1110, 7'h40);
    show_digit(1, "lzb_0050_d1", 4'b1101, 7'h12);
    show_digit(2, "lzb_0050_d2", 4'b1011, 7'h7F);
    show_digit(3, "lzb_0050_d3", 4'b0111, 7'h7F);
    do_load(16'h0000, 4'b0000);
    wait_shown(FRAME - 1, 2 * FRAME, "lzb_frame1");
    show_digit(0, "lzb_0000_d0", 4'b1110, 7'h40);
    show_digit(1, "lzb_0000_d1", 4'b1101, 7'h7F);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(9) != 0);
      reset  = ($urandom_range(299) == 0);
      if ($urandom_range(7) == 0) begin
        value = 16'($urandom);
        dp    = 4'($urandom);
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      tick();
    end
    reset  = 1'b0;
    load   = 1'b0;
    enable = 1'b1;
    repeat (2 * FRAME) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
